// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths and FSM state encoding for the SRAM arbiter
package sram_pkg;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rtl/sram_arbiter_rr_arb2.sv - two-port round-robin grant, one-hot output
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);
    always_comb begin
        o_grant = i_req;
        // On a tie the port that did not win last time gets the grant
        if (i_req == 2'b11) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter sharing one asynchronous SRAM
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UE_N,
    output logic              SRAM_LE_N
);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_last;
    logic              r_port;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_ub_lb_n;
    logic              r_dq_oe;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic [1:0]        w_grant;
    logic              w_take;
    logic              w_we_nxt;
    logic              w_ce_n_nxt;
    logic              w_oe_n_nxt;
    logic              w_we_n_nxt;
    logic              w_dq_oe_nxt;
    logic              w_ack0_nxt;
    logic              w_ack1_nxt;
    logic              w_capture;

    rr_arb2 u_rr_arb2 (
        .i_req   ({req1, req0}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_take = (r_state == ST_IDLE) && (|w_grant);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
                w_cnt_nxt   = CNT_LOAD;
            end
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes are computed from the next state so the registered pins line up with the state
    always_comb begin
        w_we_nxt    = w_take ? (w_grant[1] ? we1 : we0) : r_we;
        w_ce_n_nxt  = (w_state_nxt == ST_IDLE);
        w_oe_n_nxt  = !(((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS)) && !w_we_nxt);
        w_we_n_nxt  = !((w_state_nxt == ST_ACCESS) && w_we_nxt);
        w_dq_oe_nxt = (w_state_nxt != ST_IDLE) && w_we_nxt;
        w_ack0_nxt  = (w_state_nxt == ST_DONE) && !r_port;
        w_ack1_nxt  = (w_state_nxt == ST_DONE) && r_port;
        w_capture   = (r_state == ST_ACCESS) && (w_state_nxt == ST_DONE) && !r_we;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_last      <= 1'b1;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_lb_n   <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_we      <= w_we_nxt;
            r_ce_n    <= w_ce_n_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_we_n    <= w_we_n_nxt;
            r_ub_lb_n <= w_ce_n_nxt;
            r_dq_oe   <= w_dq_oe_nxt;
            r_ack0    <= w_ack0_nxt;
            r_ack1    <= w_ack1_nxt;
            if (w_take) begin
                r_last      <= w_grant[1];
                r_port      <= w_grant[1];
                r_wdata     <= w_grant[1] ? wdata1 : wdata0;
                r_sram_addr <= w_grant[1] ? addr1 : addr0;
            end
            if (w_capture) begin
                if (r_port) begin
                    r_rdata1 <= SRAM_DQ;
                end else begin
                    r_rdata0 <= SRAM_DQ;
                end
            end
        end
    end

    assign SRAM_DQ   = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_UE_N = r_ub_lb_n;
    assign SRAM_LE_N = r_ub_lb_n;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, ue_n, le_n;

    logic        b_rst_n, b_req0, b_we0;
    logic [19:0] b_addr0;
    logic [15:0] b_wdata0;
    logic        b_ack0, b_ack1;
    logic [15:0] b_rdata0, b_rdata1;
    logic [19:0] b_sram_addr;
    wire  [15:0] b_sram_dq;
    logic        b_ce_n, b_oe_n, b_we_n, b_ue_n, b_le_n;

    logic [15:0] mem [0:31];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // SRAM model: drives the bus on a read, stores on each edge with WE_N low
    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr[4:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[4:0]] <= sram_dq;
    end

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .SRAM_UE_N(ue_n), .SRAM_LE_N(le_n)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(b_rst_n),
        .req0(b_req0), .req1(1'b0), .we0(b_we0), .we1(1'b0),
        .addr0(b_addr0), .addr1(20'h0), .wdata0(b_wdata0), .wdata1(16'h0),
        .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .SRAM_ADDR(b_sram_addr), .SRAM_DQ(b_sram_dq),
        .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n),
        .SRAM_UE_N(b_ue_n), .SRAM_LE_N(b_le_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_low;
        int ack_at;
        int dq_ok;
        int n_ack;
        int overlap;
        int seq [0:3];

        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        rst_n = 1'b0; b_rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_wdata0 = 0;
        step(); step();
        rst_n = 1'b1; b_rst_n = 1'b1;

        chk("rst_strobes", {ce_n, oe_n, we_n, ue_n, le_n}, 5'b11111);
        chk("rst_acks", {ack0, ack1}, 2'b00);
        chk("rst_addr", sram_addr, 20'h0);
        chk("rst_rdata", {rdata0, rdata1}, 32'h0);

        // Port 0 write 0x00A5 to 0x00005
        req0 = 1; we0 = 1; addr0 = 20'h00005; wdata0 = 16'h00A5;
        n_low = 0; ack_at = 0; dq_ok = 1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (!we_n) n_low++;
            if (k <= 4 && sram_dq !== 16'h00A5) dq_ok = 0;
            if (k == 1) begin
                chk("wr_setup_strobes", {ce_n, oe_n, we_n, ue_n, le_n}, 5'b01100);
                chk("wr_setup_addr", sram_addr, 20'h00005);
            end
            if (ack0 && ack_at == 0) begin
                ack_at = k;
                req0 = 0;
                chk("wr_done_strobes", {ce_n, oe_n, we_n}, 3'b011);
            end
        end
        chk("wr_we_cycles", n_low, 2);
        chk("wr_ack_latency", ack_at, 4);
        chk("wr_dq_held", dq_ok, 1);
        chk("wr_idle_strobes", {ce_n, oe_n, we_n, ue_n, le_n}, 5'b11111);

        // Port 1 reads it back
        req1 = 1; we1 = 0; addr1 = 20'h00005;
        n_low = 0; ack_at = 0; dq_ok = 1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (!oe_n) begin
                n_low++;
                if (sram_dq !== 16'h00A5) dq_ok = 0;
            end
            if (ack0) chk("rd_no_ack0", ack0, 1'b0);
            if (ack1 && ack_at == 0) begin
                ack_at = k;
                req1 = 0;
                chk("rd_rdata_at_ack", rdata1, 16'h00A5);
            end
        end
        chk("rd_oe_cycles", n_low, 3);
        chk("rd_ack_latency", ack_at, 4);
        chk("rd_bus_value", dq_ok, 1);
        chk("rd_rdata_held", rdata1, 16'h00A5);
        chk("rd_rdata0_untouched", rdata0, 16'h0);

        // WAIT_CYCLES=1 instance: req0 dropped after SETUP still completes
        b_req0 = 1; b_we0 = 1; b_addr0 = 20'h00003; b_wdata0 = 16'h3C3C;
        n_ack = 0; ack_at = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) b_req0 = 0;
            if (b_ack0) begin
                n_ack++;
                if (ack_at == 0) ack_at = k;
            end
        end
        chk("w1_ack_count", n_ack, 1);
        chk("w1_ack_latency", ack_at, 3);

        // Reset during ACCESS of a write
        req0 = 1; we0 = 1; addr0 = 20'h00007; wdata0 = 16'h1234;
        step(); step();
        chk("abort_in_access", we_n, 1'b0);
        rst_n = 0; req0 = 0;
        step();
        chk("abort_strobes", {ce_n, oe_n, we_n, ue_n, le_n}, 5'b11111);
        chk("abort_acks", {ack0, ack1}, 2'b00);
        rst_n = 1;
        step();
        chk("abort_no_ack", {ack0, ack1}, 2'b00);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 20'h1; addr1 = 20'h2;
        ack_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (ack_at < 0 && ack0) ack_at = 0;
            if (ack_at < 0 && ack1) ack_at = 1;
        end
        chk("abort_tie_port0", ack_at, 0);

        // Both requests held from reset: grants alternate
        rst_n = 0;
        step(); step();
        rst_n = 1;
        n_ack = 0; overlap = 0;
        for (int i = 0; i < 4; i++) seq[i] = 9;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (ack0 && ack1) overlap = 1;
            if (n_ack < 4 && (ack0 || ack1)) begin
                seq[n_ack] = ack1 ? 1 : 0;
                n_ack++;
            end
        end
        req0 = 0; req1 = 0;
        chk("rr_ack_count", n_ack, 4);
        chk("rr_grant0", seq[0], 0);
        chk("rr_grant1", seq[1], 1);
        chk("rr_grant2", seq[2], 0);
        chk("rr_grant3", seq[3], 1);
        chk("rr_no_overlap", overlap, 0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, sets the number of ACCESS-state cycles (legal range 1..15).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req0, req1  input  1 each  access request from port 0 and port 1; held high until the matching ack.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  input  20 each  word address.
REQ-007 wdata0, wdata1  input  16 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-009 rdata0, rdata1  output  16 each  read data, valid while the matching ack is high and held until that port's next read.
REQ-010 SRAM_ADDR  output  20  SRAM address, registered.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UE_N, SRAM_LE_N  output  1 each  active-low SRAM strobes.

Function
REQ-013 FSM states: IDLE, SETUP, ACCESS, DONE; all strobes registered.
REQ-014 IDLE: if any req is high at the edge, grant one port and latch its we/addr/wdata; next state is SETUP.
REQ-015 Grant selection is round-robin: with both reqs high, the port not granted last wins; with one req high, that port wins.
REQ-016 The last-granted pointer resets to port 1, so port 0 wins the first tie.
REQ-017 SETUP lasts 1 cycle: SRAM_ADDR driven, CE_N=0, UE_N=LE_N=0, OE_N=0 if read.
REQ-018 ACCESS lasts WAIT_CYCLES cycles: WE_N=0 for a write; OE_N stays 0 for a read.
REQ-019 A 4-bit counter loads WAIT_CYCLES-1 on entry to ACCESS and decrements to 0; at 0, next state is DONE.
REQ-020 On the ACCESS->DONE edge: for a read, SRAM_DQ is captured into the granted port's rdata.
REQ-021 DONE lasts 1 cycle: WE_N=1, OE_N=1, CE_N=0; granted ack=1.
REQ-022 After DONE the FSM returns to IDLE; there is at least one IDLE cycle between accesses.
REQ-023 Latency from a req sampled in IDLE to ack high is WAIT_CYCLES+2 cycles.
REQ-024 SRAM_DQ carries latched wdata during SETUP, ACCESS and DONE of a write, so data is held one cycle past the WE_N rise; otherwise SRAM_DQ is high-Z.
REQ-025 A req dropped mid-access does not abort the access; the access completes and ack still pulses.
REQ-026 Inputs changing after the grant are ignored until the next IDLE.
REQ-027 ack0 and ack1 are never high in the same cycle.
REQ-028 In IDLE: CE_N=OE_N=WE_N=UE_N=LE_N=1.

Reset
REQ-029 On reset=0 at an edge, including mid-access, the next cycle has state IDLE, all strobes 1, SRAM_DQ high-Z and ack0=ack1=0.
REQ-030 Reset values: rdata0=rdata1=0, SRAM_ADDR=0, counter=0, last-granted pointer=port 1.

Structure
REQ-031 Shared package sram_pkg holds the state encoding and the constants ADDR_W=20 and DATA_W=16.
REQ-032 Round-robin grant logic is the sub-module rr_arb2 (req[1:0], last pointer -> one-hot grant).

Verification
REQ-033 Port 0 write, addr 0x00005, data 0x00A5, WAIT_CYCLES=2 -> WE_N low exactly 2 cycles, DQ=0x00A5 through DONE, ack0 4 cycles after the sampled req.
REQ-034 Port 1 reads 0x00005 after REQ-033 -> OE_N low 3 cycles, rdata1=0x00A5 while ack1=1, DQ never driven by the arbiter.
REQ-035 req0 and req1 both held high from reset -> grants alternate 0,1,0,1; acks never overlap.
REQ-036 reset=0 during the ACCESS of a write -> next cycle all strobes 1, DQ high-Z, no ack; a later port 0 request wins the first tie.
REQ-037 req0 drops after SETUP -> access completes and ack0 still pulses once; with WAIT_CYCLES=1, latency is 3 cycles.
